// File: rtl/ofmap_collector.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_collector
// Brief    : Final-psum result sink; fills an output feature map, flags done,
//            then serves random-access reads. Optional macro: OFMAP_SPIKE_EN.
// Revision : 1.0
// ============================================================================
module ofmap_collector #(
    parameter int                    WIDTH_PKT  = 32,
    parameter int                    WIDTH_DATA = 13,
    parameter int                    ADDR_W     = 8,
    parameter int                    NUM_OUT    = 63,
    parameter logic [4:0]            MEM_Y      = 5'd3,
    parameter logic [2:0]            MEM_X      = 3'd2,
    parameter logic [WIDTH_DATA-1:0] THRESH     = 13'd64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [WIDTH_PKT-1:0]  pkt_data,
    input  logic                  clear,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [WIDTH_DATA-1:0] rd_data,
    output logic                  done,
    output logic [7:0]            err_cnt,
    output logic [7:0]            dup_cnt
`ifdef OFMAP_SPIKE_EN
    ,
    output logic                  rd_spike,
    output logic [ADDR_W:0]       spike_cnt
`endif
);

    localparam logic [0:0]      S_COLLECT  = 1'b0;
    localparam logic [0:0]      S_DONE     = 1'b1;
    localparam logic [2:0]      TYPE_FINAL = 3'b011;
    localparam int              IDX_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [ADDR_W:0] NUM_OUT_C  = (ADDR_W+1)'(NUM_OUT);
    localparam logic [ADDR_W:0] LAST_C     = (ADDR_W+1)'(NUM_OUT - 1);
    localparam logic [7:0]      CNT_MAX    = 8'hFF;

    logic [2:0]            pkt_type;
    logic [4:0]            pkt_dst_y;
    logic [2:0]            pkt_dst_x;
    logic [ADDR_W-1:0]     pkt_addr;
    logic [WIDTH_DATA-1:0] pkt_val;
    logic [IDX_W-1:0]      pkt_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  pkt_fire;
    logic                  pkt_good;
    logic                  pkt_first;
    logic                  pkt_dup;
    logic                  pkt_bad;
    logic                  rd_fire;
    logic                  rd_in_range;
    logic [WIDTH_DATA-1:0] wr_data;

    logic [0:0]            state_q,    state_d;
    logic [NUM_OUT-1:0]    fill_q,     fill_d;
    logic [ADDR_W:0]       recv_cnt_q, recv_cnt_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [WIDTH_DATA-1:0] rd_data_q,  rd_data_d;
    logic [7:0]            err_cnt_q,  err_cnt_d;
    logic [7:0]            dup_cnt_q,  dup_cnt_d;

    // Result storage is deliberately unreset; the fill bits decide validity.
    logic [WIDTH_DATA-1:0] mem_q [NUM_OUT];

    assign pkt_type  = pkt_data[WIDTH_PKT-1 -: 3];
    assign pkt_dst_y = pkt_data[WIDTH_PKT-4 -: 5];
    assign pkt_dst_x = pkt_data[WIDTH_PKT-9 -: 3];
    assign pkt_addr  = pkt_data[WIDTH_DATA +: ADDR_W];
    assign pkt_val   = pkt_data[WIDTH_DATA-1:0];
    assign pkt_idx   = pkt_addr[IDX_W-1:0];
    assign rd_idx    = rd_addr[IDX_W-1:0];

    assign pkt_ready   = (state_q == S_COLLECT) && !clear;
    assign pkt_fire    = pkt_valid && pkt_ready;
    assign pkt_good    = (pkt_type == TYPE_FINAL) && (pkt_dst_y == MEM_Y) &&
                         (pkt_dst_x == MEM_X) && ({1'b0, pkt_addr} < NUM_OUT_C);
    // Fill bit lookup is only meaningful once the address passed the range check.
    assign pkt_first   = pkt_fire && pkt_good && !fill_q[pkt_idx];
    assign pkt_dup     = pkt_fire && pkt_good &&  fill_q[pkt_idx];
    assign pkt_bad     = pkt_fire && !pkt_good;
    assign rd_fire     = (state_q == S_DONE) && rd_req && !clear;
    assign rd_in_range = ({1'b0, rd_addr} < NUM_OUT_C);

`ifdef OFMAP_SPIKE_EN
    logic [NUM_OUT-1:0] spike_q,     spike_d;
    logic [ADDR_W:0]    spike_cnt_q, spike_cnt_d;
    logic               rd_spike_q,  rd_spike_d;
    logic               over_thresh;

    assign over_thresh = (pkt_val >= THRESH);
    assign wr_data     = over_thresh ? (pkt_val - THRESH) : pkt_val;

    always_comb begin
        spike_d     = spike_q;
        spike_cnt_d = spike_cnt_q;
        rd_spike_d  = rd_spike_q;
        if (clear) begin
            spike_d     = '0;
            spike_cnt_d = '0;
        end else begin
            if (pkt_first) begin
                spike_d[pkt_idx] = over_thresh;
                if (over_thresh) begin
                    spike_cnt_d = spike_cnt_q + 1'b1;
                end
            end
            if (rd_fire) begin
                rd_spike_d = rd_in_range && spike_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q     <= '0;
            spike_cnt_q <= '0;
            rd_spike_q  <= 1'b0;
        end else begin
            spike_q     <= spike_d;
            spike_cnt_q <= spike_cnt_d;
            rd_spike_q  <= rd_spike_d;
        end
    end

    assign rd_spike  = rd_spike_q;
    assign spike_cnt = spike_cnt_q;
`else
    logic unused_thresh;

    assign wr_data       = pkt_val;
    assign unused_thresh = ^THRESH;
`endif

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        recv_cnt_d = recv_cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_cnt_d  = err_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        if (clear) begin
            state_d    = S_COLLECT;
            fill_d     = '0;
            recv_cnt_d = '0;
            err_cnt_d  = '0;
            dup_cnt_d  = '0;
        end else begin
            if (pkt_first) begin
                fill_d[pkt_idx] = 1'b1;
                recv_cnt_d      = recv_cnt_q + 1'b1;
                if (recv_cnt_q == LAST_C) begin
                    state_d = S_DONE;
                end
            end
            if (pkt_dup && (dup_cnt_q != CNT_MAX)) begin
                dup_cnt_d = dup_cnt_q + 8'd1;
            end
            if (pkt_bad && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (rd_fire) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rd_in_range ? mem_q[rd_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_COLLECT;
            fill_q     <= '0;
            recv_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_cnt_q  <= '0;
            dup_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            recv_cnt_q <= recv_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_cnt_q  <= err_cnt_d;
            dup_cnt_q  <= dup_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pkt_first) begin
            mem_q[pkt_idx] <= wr_data;
        end
    end

    assign done     = (state_q == S_DONE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err_cnt  = err_cnt_q;
    assign dup_cnt  = dup_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ofmap_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_collector
// Brief    : Self-checking bench for ofmap_collector (table + random + model).
// Revision : 1.0
// ============================================================================
module tb_ofmap_collector;

    localparam int NUM_OUT = 63;
    localparam int THRESH  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_data;
    logic        clear;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [12:0] rd_data;
    logic        done;
    logic [7:0]  err_cnt;
    logic [7:0]  dup_cnt;
`ifdef OFMAP_SPIKE_EN
    logic        rd_spike;
    logic [8:0]  spike_cnt;
`endif

    always #5 clk = ~clk;

    ofmap_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .clear     (clear),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err_cnt   (err_cnt),
        .dup_cnt   (dup_cnt)
`ifdef OFMAP_SPIKE_EN
        ,
        .rd_spike  (rd_spike),
        .spike_cnt (spike_cnt)
`endif
    );

    // Reference model: one frame of results as plain arrays and counters.
    int m_mem  [NUM_OUT];
    bit m_fill [NUM_OUT];
    bit m_spk  [NUM_OUT];
    int m_recv, m_err, m_dup, m_spk_cnt, m_rd_data;
    bit m_rd_spk;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int t; int y; int x; int a; int d; int e_err; int e_dup;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_OUT; i++) begin
            m_fill[i] = 1'b0;
            m_spk[i]  = 1'b0;
        end
        m_recv = 0; m_err = 0; m_dup = 0; m_spk_cnt = 0;
    endtask

    task automatic model_pkt(input int t, input int y, input int x, input int a, input int d);
        if (t != 3 || y != 3 || x != 2 || a >= NUM_OUT) begin
            if (m_err < 255) m_err++;
        end else if (m_fill[a]) begin
            if (m_dup < 255) m_dup++;
        end else begin
            m_fill[a] = 1'b1;
            m_recv++;
`ifdef OFMAP_SPIKE_EN
            m_spk[a] = (d >= THRESH);
            m_mem[a] = m_spk[a] ? d - THRESH : d;
            if (m_spk[a]) m_spk_cnt++;
`else
            m_mem[a] = d;
`endif
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done"}, done, (m_recv == NUM_OUT) ? 1 : 0);
        check({tag, "_err"}, err_cnt, m_err);
        check({tag, "_dup"}, dup_cnt, m_dup);
`ifdef OFMAP_SPIKE_EN
        check({tag, "_spike_cnt"}, spike_cnt, m_spk_cnt);
`endif
    endtask

    task automatic send(input int t, input int y, input int x, input int a, input int d);
        bit acc;
        acc       = (m_recv < NUM_OUT);
        pkt_valid = 1'b1;
        pkt_data  = {3'(t), 5'(y), 3'(x), 8'(a), 13'(d)};
        #1;
        check("pkt_ready", pkt_ready, acc ? 1 : 0);
        @(posedge clk);
        if (acc) model_pkt(t, y, x, a, d);
        #1;
        pkt_valid = 1'b0;
        check_status("send");
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        check_status("idle");
    endtask

    task automatic send_bad();
        int t, y, x, a;
        t = 3; y = 3; x = 2; a = $urandom_range(0, NUM_OUT - 1);
        case ($urandom_range(0, 3))
            0: begin t = $urandom_range(0, 6); if (t >= 3) t++; end
            1: begin y = $urandom_range(0, 30); if (y >= 3) y++; end
            2: begin x = $urandom_range(0, 6); if (x >= 2) x++; end
            default: a = $urandom_range(NUM_OUT, 255);
        endcase
        send(t, y, x, a, $urandom_range(0, 8191));
    endtask

    task automatic read_chk(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 1);
        check({tag, "_rd_data"}, rd_data, m_rd_data);
`ifdef OFMAP_SPIKE_EN
        check({tag, "_rd_spike"}, rd_spike, m_rd_spk);
`endif
    endtask

    // Issues one read per cycle for n cycles, then one idle cycle.
    task automatic rd_burst(input int n, input int first_addr);
        bit issue;
        int a;
        issue = (m_recv == NUM_OUT);
        for (int i = 0; i < n; i++) begin
            a = (i == 0) ? first_addr : $urandom_range(0, 80);
            rd_req  = 1'b1;
            rd_addr = 8'(a);
            @(posedge clk);
            if (issue) begin
                m_rd_data = (a < NUM_OUT) ? m_mem[a] : 0;
                m_rd_spk  = (a < NUM_OUT) ? m_spk[a] : 1'b0;
            end
            #1;
            if (issue) read_chk("rd");
            else check("rd_collect_valid", rd_valid, 0);
        end
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        check("rd_idle_valid", rd_valid, 0);
        check("rd_idle_hold", rd_data, m_rd_data);
    endtask

    task automatic fill_random();
        int guard;
        guard = 0;
        while (m_recv < NUM_OUT && guard < 3000) begin
            case ($urandom_range(0, 9))
                0: send_bad();
                1: idle();
                default: send(3, 3, 2, $urandom_range(0, NUM_OUT - 1), $urandom_range(0, 8191));
            endcase
            guard++;
        end
        check("fill_random_done", done, 1);
    endtask

    task automatic fill_shuffled();
        int ord [NUM_OUT];
        int j, tmp;
        for (int i = 0; i < NUM_OUT; i++) ord[i] = i;
        for (int i = NUM_OUT - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < NUM_OUT; i++) send(3, 3, 2, ord[i], $urandom_range(0, 8191));
    endtask

    task automatic reset_now(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        m_rd_data = 0;
        m_rd_spk  = 1'b0;
        check({tag, "_rst_rd_valid"}, rd_valid, 0);
        check({tag, "_rst_rd_data"}, rd_data, 0);
        check({tag, "_rst_ready"}, pkt_ready, 1);
        check_status({tag, "_rst"});
        @(posedge clk);
        #2;
        rd_req = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input bit with_pkt, input bit with_rd);
        clear     = 1'b1;
        pkt_valid = with_pkt;
        pkt_data  = {3'd3, 5'd3, 3'd2, 8'd40, 13'd1};
        rd_req    = with_rd;
        rd_addr   = 8'd17;
        #1;
        check("clear_pkt_ready", pkt_ready, 0);
        @(posedge clk);
        model_clear();
        #1;
        clear = 1'b0; pkt_valid = 1'b0; rd_req = 1'b0;
        check("clear_rd_valid", rd_valid, 0);
        check("clear_rd_hold", rd_data, m_rd_data);
        check_status("clear");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{3, 3, 2,  5,    7, 0, 0};
        tbl[1] = '{3, 3, 2,  5,    9, 0, 1};
        tbl[2] = '{2, 3, 2,  6,    1, 1, 1};
        tbl[3] = '{3, 3, 1,  6,    1, 2, 1};
        tbl[4] = '{3, 3, 2, 63,    1, 3, 1};
        tbl[5] = '{3, 4, 2,  6,    1, 4, 1};
        tbl[6] = '{3, 3, 2,  6, 8191, 4, 1};

        rst_n = 1'b1; pkt_valid = 1'b0; pkt_data = '0; clear = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        m_rd_data = 0; m_rd_spk = 1'b0;
        model_clear();
        #3;
        reset_now("init");

        // Reverse-order fill; done must rise right after the 63rd accept.
        for (int a = NUM_OUT - 1; a >= 0; a--) send(3, 3, 2, a, a + 100);
        rd_burst(1, 17);
`ifndef OFMAP_SPIKE_EN
        check("rd17_value", rd_data, 117);
`endif
        rd_burst(12, 63);
        rd_burst(2, 255);
        send(3, 3, 2, 3, 5);

        do_clear(1'b0, 1'b1);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].t, tbl[i].y, tbl[i].x, tbl[i].a, tbl[i].d);
            check("tbl_err", err_cnt, tbl[i].e_err);
            check("tbl_dup", dup_cnt, tbl[i].e_dup);
        end
        rd_burst(2, 5);
        fill_random();
        rd_burst(1, 5);
`ifndef OFMAP_SPIKE_EN
        check("rd5_first_wins", rd_data, 7);
`endif
        rd_burst(20, 6);

        // Clear collides with a valid packet mid-frame.
        do_clear(1'b0, 1'b0);
        for (int a = 0; a < 40; a++) send(3, 3, 2, a, a);
        do_clear(1'b1, 1'b0);
        for (int a = 0; a < NUM_OUT; a++) send(3, 3, 2, a, 8191 - a);

        // Asynchronous reset while a read of an out-of-range address is pending.
        rd_burst(1, 17);
        rd_req  = 1'b1;
        rd_addr = 8'd200;
        reset_now("done");
        for (int a = 0; a < 30; a++) send(3, 3, 2, a, a);
        send_bad();
        reset_now("mid");
        fill_shuffled();
        rd_burst(1, 200);
        rd_burst(1, 62);

        // Counter saturation.
        do_clear(1'b0, 1'b0);
        for (int i = 0; i < 260; i++) send(0, 3, 2, 1, 1);
        send(3, 3, 2, 0, 1);
        for (int i = 0; i < 260; i++) send(3, 3, 2, 0, 2);
        check("err_saturated", err_cnt, 255);
        check("dup_saturated", dup_cnt, 255);

`ifdef OFMAP_SPIKE_EN
        do_clear(1'b0, 1'b0);
        send(3, 3, 2, 0, 100);
        send(3, 3, 2, 1, 30);
        send(3, 3, 2, 2, 64);
        send(3, 3, 2, 3, 63);
        check("spike_cnt_two", spike_cnt, 2);
        for (int a = 4; a < NUM_OUT; a++) send(3, 3, 2, a, $urandom_range(0, 8191));
        rd_burst(1, 0);
        check("spk0_data", rd_data, 36);
        check("spk0_flag", rd_spike, 1);
        rd_burst(1, 1);
        check("spk1_data", rd_data, 30);
        check("spk1_flag", rd_spike, 0);
        rd_burst(4, 2);
        rd_burst(1, 99);
        check("spk_oor_flag", rd_spike, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
